// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, owner codes, grant indices.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_ARB_IDLE   = 2'b00,
      ST_ARB_ACCESS = 2'b01,
      ST_ARB_RESP   = 2'b10
   } arb_state_e;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_DMA = 1'b1;

   function automatic logic [1:0] owner_of(input logic gnt_idx);
      return (gnt_idx == GNT_DMA) ? OWN_DMA : OWN_CPU;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of mem_arbiter; slave is the arbiter's view.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic        iCpuReq;
   logic        iCpuWe;
   logic [31:0] iCpuAddr;
   logic [31:0] iCpuWData;
   logic [31:0] oCpuRData;
   logic        oCpuAck;

   logic        iDmaReq;
   logic        iDmaWe;
   logic [31:0] iDmaAddr;
   logic [31:0] iDmaWData;
   logic [31:0] oDmaRData;
   logic        oDmaAck;

   logic [31:0] oMemAddr;
   logic [31:0] oMemWData;
   logic        oMemRead;
   logic        oMemWrite;
   logic [31:0] iMemRData;

   logic [1:0]  oOwner;
   arb_state_e  oState;

   modport slave (
      input  iCpuReq, iCpuWe, iCpuAddr, iCpuWData,
      input  iDmaReq, iDmaWe, iDmaAddr, iDmaWData,
      input  iMemRData,
      output oCpuRData, oCpuAck, oDmaRData, oDmaAck,
      output oMemAddr, oMemWData, oMemRead, oMemWrite,
      output oOwner, oState
   );

   modport master (
      output iCpuReq, iCpuWe, iCpuAddr, iCpuWData,
      output iDmaReq, iDmaWe, iDmaAddr, iDmaWData,
      output iMemRData,
      input  oCpuRData, oCpuAck, oDmaRData, oDmaAck,
      input  oMemAddr, oMemWData, oMemRead, oMemWrite,
      input  oOwner, oState
   );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time wins.
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt_vld,
   output logic       gnt_idx
);

   always_comb begin
      gnt_vld = |req;
      gnt_idx = (req == 2'b11) ? ~last_grant : (req[1] ? GNT_DMA : GNT_CPU);
   end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA single-memory arbiter: IDLE samples requests, ACCESS strobes memory, RESP acks the owner.
// One transaction per three cycles; all outputs are registered.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic         iCLK,
   input  logic         iRST,
   mem_arbiter_if.slave bus
);

   arb_state_e  state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        cap_we_q, cap_we_d;
   logic [31:0] cap_addr_q, cap_addr_d;
   logic [31:0] cap_wdata_q, cap_wdata_d;
   logic [1:0]  owner_q, owner_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic        dma_ack_q, dma_ack_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;
   logic [31:0] dma_rdata_q, dma_rdata_d;

   logic        gnt_vld;
   logic        gnt_idx;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;

   rr_arb2 u_rr_arb2 (
      .req        ({bus.iDmaReq, bus.iCpuReq}),
      .last_grant (last_grant_q),
      .gnt_vld    (gnt_vld),
      .gnt_idx    (gnt_idx)
   );

   assign sel_we    = gnt_idx ? bus.iDmaWe    : bus.iCpuWe;
   assign sel_addr  = gnt_idx ? bus.iDmaAddr  : bus.iCpuAddr;
   assign sel_wdata = gnt_idx ? bus.iDmaWData : bus.iCpuWData;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cap_we_d     = cap_we_q;
      cap_addr_d   = cap_addr_q;
      cap_wdata_d  = cap_wdata_q;
      owner_d      = owner_q;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      cpu_ack_d    = 1'b0;
      dma_ack_d    = 1'b0;

      case (state_q)
         ST_ARB_IDLE: begin
            owner_d = OWN_NONE;
            if (gnt_vld) begin
               state_d      = ST_ARB_ACCESS;
               last_grant_d = gnt_idx;
               owner_d      = owner_of(gnt_idx);
               cap_we_d     = sel_we;
               cap_addr_d   = sel_addr;
               cap_wdata_d  = sel_wdata;
               // Strobes are loaded here so they are live for exactly the ACCESS cycle.
               mem_read_d   = ~sel_we;
               mem_write_d  = sel_we;
               mem_addr_d   = sel_addr;
               mem_wdata_d  = sel_wdata;
            end
         end
         ST_ARB_ACCESS: begin
            state_d   = ST_ARB_RESP;
            cpu_ack_d = (owner_q == OWN_CPU);
            dma_ack_d = (owner_q == OWN_DMA);
            if (!cap_we_q && owner_q == OWN_CPU) cpu_rdata_d = bus.iMemRData;
            if (!cap_we_q && owner_q == OWN_DMA) dma_rdata_d = bus.iMemRData;
         end
         ST_ARB_RESP: begin
            state_d = ST_ARB_IDLE;
            owner_d = OWN_NONE;
         end
         default: begin
            state_d = ST_ARB_IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q      <= ST_ARB_IDLE;
         last_grant_q <= GNT_DMA;
         cap_we_q     <= 1'b0;
         cap_addr_q   <= '0;
         cap_wdata_q  <= '0;
         owner_q      <= OWN_NONE;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         dma_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cap_we_q     <= cap_we_d;
         cap_addr_q   <= cap_addr_d;
         cap_wdata_q  <= cap_wdata_d;
         owner_q      <= owner_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_ack_q    <= cpu_ack_d;
         dma_ack_q    <= dma_ack_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

   assign bus.oMemRead  = mem_read_q;
   assign bus.oMemWrite = mem_write_q;
   assign bus.oMemAddr  = mem_addr_q;
   assign bus.oMemWData = mem_wdata_q;
   assign bus.oCpuAck   = cpu_ack_q;
   assign bus.oDmaAck   = dma_ack_q;
   assign bus.oCpuRData = cpu_rdata_q;
   assign bus.oDmaRData = dma_rdata_q;
   assign bus.oOwner    = owner_q;
   assign bus.oState    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-schedule reference model checked every cycle, plus directed literal checks.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int NCYC = 1024;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        cack;
      logic        dack;
      logic [1:0]  owner;
      logic [1:0]  state;
   } exp_t;

   logic clk;
   logic rst;
   mem_arbiter_if bus();

   mem_arbiter dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents for never-written words follow a fixed pattern keyed on word index.
   function automatic logic [31:0] pattern(input int idx);
      return 32'h1234_5678 + 32'(idx - 16) * 32'h0101_0101;
   endfunction

   // Index of the most recent rising clock edge (edges at 5, 15, 25, ...).
   function automatic int cyc_now();
      if ($time < 5) return 0;
      return int'(($time - 5) / 10);
   endfunction

   // ---------------- memory attached to the DUT ----------------
   logic [31:0] mem    [256];
   bit          mem_wr [256];
   logic [7:0]  mem_idx;

   assign mem_idx       = bus.oMemAddr[9:2];
   assign bus.iMemRData = bus.oMemRead ? (mem_wr[mem_idx] ? mem[mem_idx] : pattern(int'(mem_idx))) : 32'h0;

   always @(posedge clk) begin
      if (bus.oMemWrite) begin
         mem[mem_idx]    <= bus.oMemWData;
         mem_wr[mem_idx] <= 1'b1;
      end
   end

   // ---------------- reference model: schedules each granted transaction ----------------
   exp_t        exp_tab [NCYC];
   bit          upd_cpu [NCYC];
   bit          upd_dma [NCYC];
   logic [31:0] upd_val [NCYC];
   logic [31:0] ref_mem [256];
   bit          ref_wr  [256];
   logic [31:0] m_cpu_rdata;
   logic [31:0] m_dma_rdata;
   logic        m_last;
   int          m_free;

   always @(posedge clk or posedge rst) begin
      int          n;
      logic        win;
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [7:0]  ix;
      n = cyc_now();
      if (rst) begin
         for (int k = n; k < NCYC; k++) begin
            exp_tab[k] = '0;
            upd_cpu[k] = 1'b0;
            upd_dma[k] = 1'b0;
         end
         m_cpu_rdata = '0;
         m_dma_rdata = '0;
         m_last      = 1'b1;
         m_free      = n + 1;
      end else if (n < NCYC - 2) begin
         if (upd_cpu[n]) m_cpu_rdata = upd_val[n];
         if (upd_dma[n]) m_dma_rdata = upd_val[n];
         if (n >= m_free && (bus.iCpuReq || bus.iDmaReq)) begin
            win    = (bus.iCpuReq && bus.iDmaReq) ? ~m_last : bus.iDmaReq;
            m_last = win;
            we     = win ? bus.iDmaWe    : bus.iCpuWe;
            a      = win ? bus.iDmaAddr  : bus.iCpuAddr;
            wd     = win ? bus.iDmaWData : bus.iCpuWData;
            ix     = a[9:2];
            exp_tab[n].state   = ST_ARB_ACCESS;
            exp_tab[n].owner   = win ? 2'b10 : 2'b01;
            exp_tab[n].rd      = ~we;
            exp_tab[n].wr      = we;
            exp_tab[n].addr    = a;
            exp_tab[n].wdata   = wd;
            exp_tab[n+1].state = ST_ARB_RESP;
            exp_tab[n+1].owner = win ? 2'b10 : 2'b01;
            exp_tab[n+1].cack  = ~win;
            exp_tab[n+1].dack  = win;
            if (we) begin
               ref_mem[ix] = wd;
               ref_wr[ix]  = 1'b1;
            end else begin
               upd_val[n+1] = ref_wr[ix] ? ref_mem[ix] : pattern(int'(ix));
               if (win) upd_dma[n+1] = 1'b1;
               else     upd_cpu[n+1] = 1'b1;
            end
            m_free = n + 3;
         end
      end
   end

   // ---------------- checking ----------------
   int nvec;
   int nmis;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nmis++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc_now(), got, want);
      end
   endtask

   task automatic cmp_cycle();
      int   n;
      exp_t e;
      n = cyc_now();
      e = exp_tab[n];
      chk("mem_read",  32'(bus.oMemRead),  32'(e.rd));
      chk("mem_write", 32'(bus.oMemWrite), 32'(e.wr));
      chk("mem_addr",  bus.oMemAddr,       e.addr);
      chk("mem_wdata", bus.oMemWData,      e.wdata);
      chk("cpu_ack",   32'(bus.oCpuAck),   32'(e.cack));
      chk("dma_ack",   32'(bus.oDmaAck),   32'(e.dack));
      chk("owner",     32'(bus.oOwner),    32'(e.owner));
      chk("state",     32'(bus.oState),    32'(e.state));
      chk("cpu_rdata", bus.oCpuRData,      m_cpu_rdata);
      chk("dma_rdata", bus.oDmaRData,      m_dma_rdata);
   endtask

   task automatic tick();
      @(negedge clk);
      cmp_cycle();
   endtask

   task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      bus.iCpuReq = req; bus.iCpuWe = we; bus.iCpuAddr = addr; bus.iCpuWData = wd;
   endtask

   task automatic set_dma(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      bus.iDmaReq = req; bus.iDmaWe = we; bus.iDmaAddr = addr; bus.iDmaWData = wd;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dma(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int          rd_cnt, wr_cnt, ack_at, cack_n, dack_n, both_n, acks, alt_bad, prev, own_n;
      logic [31:0] got_rd, got_a, got_wd;
      logic [1:0]  owners [3];
      bit          seen;

      nvec = 0;
      nmis = 0;
      rst  = 1'b1;
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dma(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      chk("rst_owner",     32'(bus.oOwner),    32'h0);
      chk("rst_state",     32'(bus.oState),    32'(ST_ARB_IDLE));
      chk("rst_cpu_rdata", bus.oCpuRData,      32'h0);
      chk("rst_mem_read",  32'(bus.oMemRead),  32'h0);
      rst = 1'b0;

      // CPU read of 0x40 straight after reset.
      set_cpu(1'b1, 1'b0, 32'h0000_0040, 32'h0);
      rd_cnt = 0; ack_at = -1; dack_n = 0; got_rd = '0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (bus.oMemRead) rd_cnt++;
         if (bus.oDmaAck) dack_n++;
         if (bus.oCpuAck) begin
            ack_at = i;
            got_rd = bus.oCpuRData;
            bus.iCpuReq = 1'b0;
         end
      end
      chk("t1_read_cycles", 32'(rd_cnt), 32'd1);
      chk("t1_ack_tick",    32'(ack_at), 32'd2);
      chk("t1_cpu_rdata",   got_rd,      32'h1234_5678);
      chk("t1_dma_acks",    32'(dack_n), 32'd0);

      // Both ports read continuously for 30 cycles.
      do_reset();
      set_cpu(1'b1, 1'b0, 32'h0000_0040, 32'h0);
      set_dma(1'b1, 1'b0, 32'h0000_0084, 32'h0);
      own_n = 0; acks = 0; cack_n = 0; dack_n = 0; both_n = 0; alt_bad = 0; prev = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (bus.oState == ST_ARB_ACCESS && own_n < 3) begin
            owners[own_n] = bus.oOwner;
            own_n++;
         end
         if (bus.oCpuAck && bus.oDmaAck) both_n++;
         if (bus.oCpuAck || bus.oDmaAck) begin
            acks++;
            if (bus.oCpuAck) cack_n++;
            if (bus.oDmaAck) dack_n++;
            if (prev == int'(bus.oDmaAck)) alt_bad++;
            prev = int'(bus.oDmaAck);
         end
      end
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dma(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t2_owner_first",  32'(owners[0]), 32'h1);
      chk("t2_owner_second", 32'(owners[1]), 32'h2);
      chk("t2_owner_third",  32'(owners[2]), 32'h1);
      chk("t2_acks",         32'(acks),      32'd10);
      chk("t2_cpu_acks",     32'(cack_n),    32'd5);
      chk("t2_dma_acks",     32'(dack_n),    32'd5);
      chk("t2_double_acks",  32'(both_n),    32'd0);
      chk("t2_alternation",  32'(alt_bad),   32'd0);

      // DMA write of 0xDEADBEEF to 0x100.
      set_dma(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
      wr_cnt = 0; got_a = '0; got_wd = '0; got_rd = '0; seen = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (bus.oMemWrite) begin
            wr_cnt++;
            got_a  = bus.oMemAddr;
            got_wd = bus.oMemWData;
         end
         if (bus.oDmaAck) begin
            seen   = 1'b1;
            got_rd = bus.oDmaRData;
            bus.iDmaReq = 1'b0;
         end
      end
      chk("t3_write_cycles", 32'(wr_cnt), 32'd1);
      chk("t3_write_addr",   got_a,       32'h0000_0100);
      chk("t3_write_data",   got_wd,      32'hDEAD_BEEF);
      chk("t3_ack_seen",     32'(seen),   32'd1);
      chk("t3_dma_rdata",    got_rd,      32'h2345_6789);
      chk("t3_mem_content",  mem[64],     32'hDEAD_BEEF);

      // CPU request arrives while a DMA read is in ACCESS.
      set_dma(1'b1, 1'b0, 32'h0000_0088, 32'h0);
      tick();
      chk("t4_dma_access", 32'(bus.oState), 32'(ST_ARB_ACCESS));
      chk("t4_dma_addr",   bus.oMemAddr,    32'h0000_0088);
      set_cpu(1'b1, 1'b0, 32'h0000_01C0, 32'h0);
      #1;
      chk("t4_dma_addr_hold", bus.oMemAddr, 32'h0000_0088);
      tick();
      chk("t4_dma_ack",   32'(bus.oDmaAck), 32'd1);
      chk("t4_dma_rdata", bus.oDmaRData,    32'h2446_688A);
      bus.iCpuAddr = 32'h0000_00C0;
      tick();
      tick();
      chk("t4_cpu_owner", 32'(bus.oOwner), 32'h1);
      chk("t4_cpu_addr",  bus.oMemAddr,    32'h0000_00C0);
      tick();
      chk("t4_cpu_ack",   32'(bus.oCpuAck), 32'd1);
      chk("t4_cpu_rdata", bus.oCpuRData,    32'h3254_7698);
      bus.iCpuReq = 1'b0;
      seen = 1'b0;
      for (int i = 1; i <= 6 && !seen; i++) begin
         tick();
         if (bus.oDmaAck) begin
            seen = 1'b1;
            bus.iDmaReq = 1'b0;
         end
      end
      chk("t4_dma_second_ack", 32'(seen), 32'd1);
      tick();
      tick();

      // Reset in the middle of a CPU write ACCESS cycle.
      set_cpu(1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D);
      tick();
      chk("t5_write_strobe", 32'(bus.oMemWrite), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("t5_strobe_drop",   32'(bus.oMemWrite), 32'd0);
      chk("t5_state_idle",    32'(bus.oState),    32'(ST_ARB_IDLE));
      chk("t5_owner_none",    32'(bus.oOwner),    32'h0);
      chk("t5_cpu_rdata_clr", bus.oCpuRData,      32'h0);
      chk("t5_dma_rdata_clr", bus.oDmaRData,      32'h0);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      rst = 1'b0;
      acks = 0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (bus.oCpuAck || bus.oDmaAck) acks++;
      end
      chk("t5_no_ack",       32'(acks),        32'd0);
      chk("t5_mem_untouched", 32'(mem_wr[128]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: iCLK  in  1  clock (rising edge); iRST  in  1  asynchronous active-high reset.
REQ-002 Port 0 (CPU) inputs SHALL be: iCpuReq  in  1  request; iCpuWe  in  1  1=write; iCpuAddr  in  32  byte address; iCpuWData  in  32  write data.
REQ-003 Port 0 (CPU) outputs SHALL be: oCpuRData  out  32  read data; oCpuAck  out  1  completion pulse.
REQ-004 Port 1 (DMA) inputs SHALL be: iDmaReq  in  1; iDmaWe  in  1; iDmaAddr  in  32; iDmaWData  in  32.
REQ-005 Port 1 (DMA) outputs SHALL be: oDmaRData  out  32; oDmaAck  out  1.
REQ-006 Memory outputs SHALL be: oMemAddr  out  32; oMemWData  out  32; oMemRead  out  1; oMemWrite  out  1.
REQ-007 Memory input SHALL be: iMemRData  in  32, valid the cycle after oMemRead.
REQ-008 Status outputs SHALL be: oOwner  out  2  (00 none, 01 CPU, 10 DMA); oState  out  2  present state.

Function
REQ-009 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-010 IDLE SHALL evaluate iCpuReq/iDmaReq at each rising edge.
REQ-011 If any request is high, IDLE SHALL go to ACCESS, else stay in IDLE.
REQ-012 ACCESS SHALL always go to RESP; RESP SHALL always go to IDLE.
REQ-013 On the IDLE->ACCESS edge the winner's We, Addr and WData SHALL be captured into internal registers, and the winner into oOwner.
REQ-014 Requester signals SHALL be ignored outside IDLE.
REQ-015 In ACCESS, oMemAddr/oMemWData SHALL come from the captured registers, with oMemRead=!We and oMemWrite=We, each for exactly one cycle.
REQ-016 Outside ACCESS, oMemRead=oMemWrite=0 and oMemAddr=oMemWData=0.
REQ-017 In RESP, the owner's Ack SHALL be high for exactly one cycle; the other Ack SHALL stay 0.
REQ-018 On a read, iMemRData SHALL be registered into the owner's RData on the ACCESS->RESP edge, so it is valid during the Ack cycle.
REQ-019 Each RData SHALL hold its value until that port's next read completes; writes SHALL NOT change RData.
REQ-020 oOwner SHALL stay valid through ACCESS and RESP and SHALL be 00 in IDLE.
REQ-021 Latency SHALL be: request sampled at edge k, memory strobe in cycle k..k+1, Ack in cycle k+1..k+2.
REQ-022 A transaction SHALL take 3 cycles including the IDLE cycle; maximum throughput SHALL be 1 access per 3 cycles.
REQ-023 Requester contract: hold Req/We/Addr/WData stable from assertion until Ack is sampled, and deassert Req on the edge ending the Ack cycle unless issuing a new access.
REQ-024 A Req still high in the IDLE cycle after Ack SHALL be treated as a new transaction.
REQ-025 Arbitration SHALL be round-robin: a 1-bit lastGrant register, updated on each grant.
REQ-026 On a simultaneous request, the port not equal to lastGrant SHALL win.
REQ-027 A single request SHALL win regardless of lastGrant.
REQ-028 With both ports requesting continuously, grants SHALL alternate strictly, so neither port waits more than one transaction.
REQ-029 A request arriving during ACCESS/RESP SHALL wait for the next IDLE with no loss.
REQ-030 Any pstate encoding outside the three states SHALL go to IDLE with all strobes 0.

Reset
REQ-031 iRST SHALL asynchronously force: state=IDLE, lastGrant=DMA (so CPU wins the first tie), captured registers=0, oCpuRData=oDmaRData=0, both Acks=0, oOwner=00, all memory outputs 0.
REQ-032 Reset during ACCESS SHALL abort the transaction: no Ack is issued, and any write strobe is removed immediately.
REQ-033 After reset release, the first evaluation SHALL occur at the next rising edge.

Structure
REQ-034 State encodings (ST_ARB_IDLE/ACCESS/RESP) and owner codes (OWN_NONE/CPU/DMA) SHALL live in the shared parameter include beside the multicycle control state constants.
REQ-035 One sub-module, rr_arb2 (combinational 2-input round-robin pick from req[1:0] and lastGrant), SHALL be instantiated; everything else stays in mem_arbiter.

Verification
REQ-036 After reset, CPU read only, Addr=0x0000_0040, memory model returns 0x1234_5678: oMemRead high for exactly 1 cycle, oCpuAck pulses 2 cycles after Req is sampled, oCpuRData=0x1234_5678, oDmaAck never high.
REQ-037 After reset, CPU and DMA request on the same edge: CPU granted first (oOwner=01), then DMA (oOwner=10); the third tie goes to CPU.
REQ-038 DMA write Addr=0x100, WData=0xDEAD_BEEF: oMemWrite=1 for one cycle with those values; oDmaRData unchanged; memory model holds 0xDEAD_BEEF.
REQ-039 CPU Req asserted during a DMA ACCESS cycle: CPU served in the very next transaction; DMA captured Addr not corrupted by CPU Addr changes.
REQ-040 iRST asserted mid-ACCESS of a write: oMemWrite drops asynchronously, no Ack, state=IDLE, RData=0.
REQ-041 Both ports requesting for 30 cycles: exactly 10 Acks, alternating 5 CPU / 5 DMA, never two Acks in one cycle.
